// File: rtl/nvme_port_reset_sequencer.sv
// ============================================================================
// nvme_port_reset_sequencer : PERST# / link bring-up sequencer with bounded retry
// Revision: 1.0
// ============================================================================
`default_nettype none

module nvme_port_reset_sequencer #(
  parameter int T_ASSERT       = 25000,
  parameter int T_LINK_TIMEOUT = 250000,
  parameter int T_STABLE       = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_perstn_sync,
  input  logic       enable,
  input  logic       link_up,
  input  logic       retry_req,
  output logic       oc0a_perstn,
  output logic       link_ready,
  output logic       fail,
  output logic [3:0] attempt_cnt,
  output logic [2:0] state_o
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_assert = 3'd1;
  localparam logic [2:0] c_st_wait   = 3'd2;
  localparam logic [2:0] c_st_linked = 3'd3;
  localparam logic [2:0] c_st_fail   = 3'd4;

  localparam logic [CNT_W-1:0] c_assert_last  = CNT_W'(T_ASSERT - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(T_LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(T_STABLE - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [3:0]       c_max_retries  = 4'(MAX_RETRIES);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_stable;
  logic [3:0]       r_attempt;
  logic             w_attempt_clr;
  logic             w_attempt_inc;
  logic             w_timing;
  logic             r_perstn;
  logic             r_link_ready;
  logic             r_fail;
  logic             w_perstn_d;
  logic             w_link_ready_d;
  logic             w_fail_d;

  // State register plus the timer / stable / attempt counters that follow it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_timer   <= '0;
      r_stable  <= '0;
      r_attempt <= 4'd0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state != r_state) begin
        r_timer <= '0;
      end else if (w_timing) begin
        r_timer <= r_timer + c_cnt_one;
      end

      if ((r_state != c_st_wait) || (w_next_state != c_st_wait) || !link_up) begin
        r_stable <= '0;
      end else begin
        r_stable <= r_stable + c_cnt_one;
      end

      if (w_attempt_clr) begin
        r_attempt <= 4'd0;
      end else if (w_attempt_inc && (r_attempt != 4'hF)) begin
        r_attempt <= r_attempt + 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_attempt_clr = 1'b0;
    w_attempt_inc = 1'b0;
    w_timing      = (r_state == c_st_assert) || (r_state == c_st_wait);

    if (!host_perstn_sync || !enable) begin
      w_next_state  = c_st_idle;
      w_attempt_clr = 1'b1;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_next_state = c_st_assert;
        end
        c_st_assert: begin
          if (r_timer == c_assert_last) begin
            w_next_state = c_st_wait;
          end
        end
        c_st_wait: begin
          // A completed stable window beats a timeout landing on the same cycle
          if (link_up && (r_stable == c_stable_last)) begin
            w_next_state = c_st_linked;
          end else if (r_timer == c_timeout_last) begin
            if (r_attempt == c_max_retries) begin
              w_next_state = c_st_fail;
            end else begin
              w_next_state  = c_st_assert;
              w_attempt_inc = 1'b1;
            end
          end
        end
        c_st_linked: begin
          if (!link_up) begin
            if (r_attempt == c_max_retries) begin
              w_next_state = c_st_fail;
            end else begin
              w_next_state  = c_st_assert;
              w_attempt_inc = 1'b1;
            end
          end
        end
        c_st_fail: begin
          if (retry_req) begin
            w_next_state  = c_st_assert;
            w_attempt_clr = 1'b1;
          end
        end
        default: begin
          w_next_state = c_st_idle;
        end
      endcase
    end
  end

  always_comb begin
    w_perstn_d     = (r_state == c_st_wait) || (r_state == c_st_linked);
    w_link_ready_d = (r_state == c_st_linked);
    w_fail_d       = (r_state == c_st_fail);
  end

  // Outputs are decoded from the current state, so they lag a transition by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perstn     <= 1'b0;
      r_link_ready <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_perstn     <= w_perstn_d;
      r_link_ready <= w_link_ready_d;
      r_fail       <= w_fail_d;
    end
  end

  assign oc0a_perstn = r_perstn;
  assign link_ready  = r_link_ready;
  assign fail        = r_fail;
  assign attempt_cnt = r_attempt;
  assign state_o     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_nvme_port_reset_sequencer.sv
// ============================================================================
// tb_nvme_port_reset_sequencer : vector table, corner sequences and random run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nvme_port_reset_sequencer;

  localparam int TA   = 8;
  localparam int TL   = 20;
  localparam int TS   = 4;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_perstn_sync = 1'b1;
  logic       enable = 1'b1;
  logic       link_up = 1'b0;
  logic       retry_req = 1'b0;
  logic       oc0a_perstn;
  logic       link_ready;
  logic       fail;
  logic [3:0] attempt_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  nvme_port_reset_sequencer #(
    .T_ASSERT(TA), .T_LINK_TIMEOUT(TL), .T_STABLE(TS), .MAX_RETRIES(MAXR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .host_perstn_sync(host_perstn_sync), .enable(enable),
    .link_up(link_up), .retry_req(retry_req), .oc0a_perstn(oc0a_perstn),
    .link_ready(link_ready), .fail(fail), .attempt_cnt(attempt_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase number (spec encoding), cycles spent in the phase,
  // current run of consecutive link_up highs, and failed-attempt tally.
  int m_state, m_age, m_run, m_att;
  bit e_perstn, e_ready, e_fail;

  function automatic void m_go(int s);
    m_state = s;
    m_age   = 0;
    m_run   = 0;
  endfunction

  function automatic void m_lose();
    if (m_att == MAXR) m_go(4);
    else begin
      m_att = (m_att < 15) ? m_att + 1 : 15;
      m_go(1);
    end
  endfunction

  function automatic void model_reset();
    m_go(0);
    m_att = 0;
    e_perstn = 0; e_ready = 0; e_fail = 0;
  endfunction

  function automatic void model_step();
    int old;
    old = m_state;
    e_perstn = (old == 2) || (old == 3);
    e_ready  = (old == 3);
    e_fail   = (old == 4);
    if (!host_perstn_sync || !enable) begin
      m_att = 0;
      m_go(0);
    end else begin
      case (old)
        0: m_go(1);
        1: begin
          m_age++;
          if (m_age == TA) m_go(2);
        end
        2: begin
          m_age++;
          m_run = link_up ? m_run + 1 : 0;
          if (m_run == TS) m_go(3);
          else if (m_age == TL) m_lose();
        end
        3: if (!link_up) m_lose();
        4: if (retry_req) begin m_att = 0; m_go(1); end
        default: m_go(0);
      endcase
    end
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("model_state", int'(state_o), m_state);
    chk("model_perstn", int'(oc0a_perstn), int'(e_perstn));
    chk("model_link_ready", int'(link_ready), int'(e_ready));
    chk("model_fail", int'(fail), int'(e_fail));
    chk("model_attempt", int'(attempt_cnt), m_att);
  endtask

  typedef struct {
    bit host; bit en; bit link; bit retry; int n;
    int st; bit perstn; bit ready; bit fl; int att;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit h, bit e, bit l, bit r, int n,
                              int st, bit p, bit rd, bit f, int a);
    vec_t v;
    v.host = h; v.en = e; v.link = l; v.retry = r; v.n = n;
    v.st = st; v.perstn = p; v.ready = rd; v.fl = f; v.att = a;
    return v;
  endfunction

  initial begin
    int n, hi, lo, flip_div;

    //           host en link retry n   state perstn ready fail att
    tbl.push_back(mk(1, 1, 0, 0,  9, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  6, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  4, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  1, 3, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  7, 2, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 20, 1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 28, 4, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0,  1, 4, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 0, 0,  5, 4, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 0, 1,  1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0,  8, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  3, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  3, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  1, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  1, 3, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  8, 2, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  3, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  8, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 19, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  1, 1, 0, 0, 0, 0));

    model_reset();
    repeat (3) tick();
    chk("reset_state", int'(state_o), 0);
    chk("reset_perstn", int'(oc0a_perstn), 0);
    chk("reset_attempt", int'(attempt_cnt), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      host_perstn_sync = tbl[i].host;
      enable           = tbl[i].en;
      link_up          = tbl[i].link;
      retry_req        = tbl[i].retry;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_state", i), int'(state_o), tbl[i].st);
      chk($sformatf("vec%0d_perstn", i), int'(oc0a_perstn), int'(tbl[i].perstn));
      chk($sformatf("vec%0d_link_ready", i), int'(link_ready), int'(tbl[i].ready));
      chk($sformatf("vec%0d_fail", i), int'(fail), int'(tbl[i].fl));
      chk($sformatf("vec%0d_attempt", i), int'(attempt_cnt), tbl[i].att);
    end

    // Retry pulse widths, then an asynchronous reset in the middle of ASSERT
    host_perstn_sync = 1'b1; enable = 1'b1; link_up = 1'b0; retry_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (oc0a_perstn !== 1'b1 && n < 100) begin tick(); n++; end
    chk("perstn_first_rise", int'(oc0a_perstn), 1);
    hi = 0;
    while (oc0a_perstn === 1'b1 && hi < 100) begin tick(); hi++; end
    chk("perstn_high_run", hi, TL);
    lo = 0;
    while (oc0a_perstn === 1'b0 && lo < 100) begin tick(); lo++; end
    chk("perstn_low_run", lo, TA);
    n = 0;
    while (state_o !== 3'd1 && n < 100) begin tick(); n++; end
    chk("second_retry_assert", int'(state_o), 1);
    repeat (3) tick();
    chk("attempt_before_rst", int'(attempt_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_attempt", int'(attempt_cnt), 0);
    chk("async_rst_perstn", int'(oc0a_perstn), 0);
    model_reset();
    tick();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      flip_div = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 10 : 40);
      for (int c = 0; c < 500; c++) begin
        host_perstn_sync = ($urandom_range(0, 199) != 0);
        enable           = ($urandom_range(0, 199) != 0);
        retry_req        = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, flip_div - 1) == 0) link_up = ~link_up;
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
